id_ex_stage: RTL and testbench

- Decode stage plus ID/EX pipeline register for the 5-stage RV32I core.
- Sits between the IF/ID register and the execute stage, around the register file:
  - drives the register-file read addresses;
  - takes the register-file read data back;
  - generates the immediate and control signals;
  - applies the write-back bypass and detects load-use hazards;
  - registers everything for EX.

---
 rtl/riscv_pkg.sv | 56 +++++
 rtl/id_ex_stage_imm_gen.sv | 33 +++
 rtl/id_ex_stage.sv | 140 ++++++++++++++
 tb/tb_id_ex_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcodes, decoded control bundle and decode helpers
package riscv_pkg;

   localparam int REG_W = 5;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic alusrc;
      logic memread;
      logic memwrite;
      logic regwrite;
      logic memtoreg;
      logic branch;
      logic jump;
      logic illegal;
   } ctrl_t;

   function automatic ctrl_t decode_ctrl(input logic [6:0] op);
      ctrl_t c;
      c = '0;
      case (op)
         OP_R:             c.regwrite = 1'b1;
         OP_IMM:           begin c.alusrc = 1'b1; c.regwrite = 1'b1; end
         OP_LOAD:          begin c.alusrc = 1'b1; c.memread = 1'b1;
                                 c.regwrite = 1'b1; c.memtoreg = 1'b1; end
         OP_STORE:         begin c.alusrc = 1'b1; c.memwrite = 1'b1; end
         OP_BRANCH:        c.branch = 1'b1;
         OP_LUI, OP_AUIPC: begin c.alusrc = 1'b1; c.regwrite = 1'b1; end
         OP_JAL:           begin c.jump = 1'b1; c.regwrite = 1'b1; end
         OP_JALR:          begin c.jump = 1'b1; c.alusrc = 1'b1; c.regwrite = 1'b1; end
         default:          c.illegal = 1'b1;
      endcase
      return c;
   endfunction

   function automatic logic uses_rs1(input logic [6:0] op);
      return (op == OP_R) || (op == OP_IMM) || (op == OP_LOAD) ||
             (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JALR);
   endfunction

   function automatic logic uses_rs2(input logic [6:0] op);
      return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
   endfunction

endpackage

// File: rtl/id_ex_stage_imm_gen.sv
// rtl/id_ex_stage_imm_gen.sv - sign-extended immediate for each RV32I format
module imm_gen
   import riscv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [31:0]      instr,
   output logic [WIDTH-1:0] imm
);

   logic [31:0] imm32;

   always_comb begin
      imm32 = '0;
      case (instr[6:0])
         OP_IMM, OP_LOAD, OP_JALR:
            imm32 = {{20{instr[31]}}, instr[31:20]};
         OP_STORE:
            imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         OP_BRANCH:
            imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         OP_LUI, OP_AUIPC:
            imm32 = {instr[31:12], 12'b0};
         OP_JAL:
            imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default:
            imm32 = '0;
      endcase
   end

   assign imm = WIDTH'($signed(imm32));

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - RV32I decode, WB bypass, load-use detect and ID/EX register
module id_ex_stage #(
   parameter int          WIDTH     = 32,
   parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [31:0]      id_instr,
   input  logic [WIDTH-1:0] id_pc,
   output logic [4:0]       rf_read1,
   output logic [4:0]       rf_read2,
   input  logic [WIDTH-1:0] rf_data1,
   input  logic [WIDTH-1:0] rf_data2,
   input  logic             wb_regwrite,
   input  logic [4:0]       wb_rd,
   input  logic [WIDTH-1:0] wb_data,
   input  logic             ex_flush,
   input  logic             ex_hold,
   output logic             stall,
   output logic             ex_valid,
   output logic [WIDTH-1:0] ex_pc,
   output logic [WIDTH-1:0] ex_rs1_val,
   output logic [WIDTH-1:0] ex_rs2_val,
   output logic [WIDTH-1:0] ex_imm,
   output logic [4:0]       ex_rs1,
   output logic [4:0]       ex_rs2,
   output logic [4:0]       ex_rd,
   output logic [2:0]       ex_funct3,
   output logic             ex_funct7b5,
   output logic             ex_alusrc,
   output logic             ex_memread,
   output logic             ex_memwrite,
   output logic             ex_regwrite,
   output logic             ex_memtoreg,
   output logic             ex_branch,
   output logic             ex_jump,
   output logic             ex_illegal
);
   import riscv_pkg::*;

   typedef struct packed {
      logic             valid;
      logic [WIDTH-1:0] pc;
      logic [WIDTH-1:0] rs1_val;
      logic [WIDTH-1:0] rs2_val;
      logic [WIDTH-1:0] imm;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [REG_W-1:0] rd;
      logic [2:0]       funct3;
      logic             funct7b5;
      ctrl_t            ctrl;
   } idex_t;

   idex_t idex_d, idex_q, dec;

   logic [6:0]       opcode;
   logic [REG_W-1:0] rs1, rs2, rd;
   logic [WIDTH-1:0] imm;
   logic             is_nop;
   logic             load_use;

   assign opcode   = id_instr[6:0];
   assign rs1      = id_instr[19:15];
   assign rs2      = id_instr[24:20];
   assign rd       = id_instr[11:7];
   assign rf_read1 = rs1;
   assign rf_read2 = rs2;
   assign is_nop   = (id_instr == NOP_INSTR);

   imm_gen #(.WIDTH(WIDTH)) u_imm_gen (
      .instr (id_instr),
      .imm   (imm)
   );

   // The register file writes at the edge, so a same-cycle WB result must be bypassed here.
   always_comb begin
      dec          = '0;
      dec.valid    = 1'b1;
      dec.pc       = id_pc;
      dec.rs1_val  = (wb_regwrite && wb_rd != '0 && wb_rd == rs1) ? wb_data : rf_data1;
      dec.rs2_val  = (wb_regwrite && wb_rd != '0 && wb_rd == rs2) ? wb_data : rf_data2;
      dec.imm      = imm;
      dec.rs1      = rs1;
      dec.rs2      = rs2;
      dec.rd       = rd;
      dec.funct3   = id_instr[14:12];
      dec.funct7b5 = id_instr[30];
      dec.ctrl     = decode_ctrl(opcode);
      dec.ctrl.regwrite = dec.ctrl.regwrite && (rd != '0) && !is_nop;
   end

   assign load_use = id_valid && idex_q.valid && idex_q.ctrl.memread && (idex_q.rd != '0) &&
                     ((idex_q.rd == rs1 && uses_rs1(opcode)) ||
                      (idex_q.rd == rs2 && uses_rs2(opcode)));

   assign stall = load_use && !ex_flush && !ex_hold;

   always_comb begin
      idex_d = idex_q;
      if (ex_flush) begin
         idex_d = '0;
      end else if (ex_hold) begin
         idex_d = idex_q;
      end else if (load_use || !id_valid) begin
         idex_d = '0;
      end else begin
         idex_d = dec;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idex_q <= '0;
      end else begin
         idex_q <= idex_d;
      end
   end

   assign ex_valid    = idex_q.valid;
   assign ex_pc       = idex_q.pc;
   assign ex_rs1_val  = idex_q.rs1_val;
   assign ex_rs2_val  = idex_q.rs2_val;
   assign ex_imm      = idex_q.imm;
   assign ex_rs1      = idex_q.rs1;
   assign ex_rs2      = idex_q.rs2;
   assign ex_rd       = idex_q.rd;
   assign ex_funct3   = idex_q.funct3;
   assign ex_funct7b5 = idex_q.funct7b5;
   assign ex_alusrc   = idex_q.ctrl.alusrc;
   assign ex_memread  = idex_q.ctrl.memread;
   assign ex_memwrite = idex_q.ctrl.memwrite;
   assign ex_regwrite = idex_q.ctrl.regwrite;
   assign ex_memtoreg = idex_q.ctrl.memtoreg;
   assign ex_branch   = idex_q.ctrl.branch;
   assign ex_jump     = idex_q.ctrl.jump;
   assign ex_illegal  = idex_q.ctrl.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed vector and sequence bench for id_ex_stage
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [31:0] id_instr, id_pc;
   logic [4:0]  rf_read1, rf_read2;
   logic [31:0] rf_data1, rf_data2;
   logic        wb_regwrite;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        ex_flush, ex_hold, stall, ex_valid;
   logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [2:0]  ex_funct3;
   logic        ex_funct7b5, ex_alusrc, ex_memread, ex_memwrite, ex_regwrite;
   logic        ex_memtoreg, ex_branch, ex_jump, ex_illegal;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
      .rf_read1(rf_read1), .rf_read2(rf_read2), .rf_data1(rf_data1), .rf_data2(rf_data2),
      .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
      .ex_flush(ex_flush), .ex_hold(ex_hold), .stall(stall), .ex_valid(ex_valid),
      .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
      .ex_funct7b5(ex_funct7b5), .ex_alusrc(ex_alusrc), .ex_memread(ex_memread),
      .ex_memwrite(ex_memwrite), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
      .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_illegal(ex_illegal)
   );

   typedef struct {
      logic        vin;
      logic [31:0] instr;
      logic [31:0] rf1;
      logic [31:0] rf2;
      logic        wbr;
      logic [4:0]  wbrd;
      logic [31:0] wbd;
      logic        ev;
      logic [31:0] eimm;
      logic [31:0] ev1;
      logic [31:0] ev2;
      logic [4:0]  erd;
      logic [7:0]  ectrl;
      logic        ef7;
   } vec_t;

   vec_t vecs[20];

   function automatic logic [7:0] ctrl_now();
      return {ex_alusrc, ex_memread, ex_memwrite, ex_regwrite,
              ex_memtoreg, ex_branch, ex_jump, ex_illegal};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] instr,
                        input logic [31:0] r1, input logic [31:0] r2);
      id_valid = v; id_instr = instr; rf_data1 = r1; rf_data2 = r2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // ctrl bits: {alusrc, memread, memwrite, regwrite, memtoreg, branch, jump, illegal}
      vecs[0]  = '{1, 32'h002081B3, 1, 2, 0, 0, 0, 1, 32'h0, 1, 2, 3, 8'h10, 0};
      vecs[1]  = '{1, 32'hFFF00293, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF, 0, 0, 5, 8'h90, 1};
      vecs[2]  = '{1, 32'h0020A423, 32'h1000, 32'h55, 0, 0, 0, 1, 32'h8, 32'h1000, 32'h55, 8, 8'hA0, 0};
      vecs[3]  = '{1, 32'hFE208EE3, 3, 4, 0, 0, 0, 1, 32'hFFFFFFFC, 3, 4, 29, 8'h04, 1};
      vecs[4]  = '{1, 32'h123450B7, 0, 0, 0, 0, 0, 1, 32'h12345000, 0, 0, 1, 8'h90, 0};
      vecs[5]  = '{1, 32'hFFFFF117, 0, 0, 0, 0, 0, 1, 32'hFFFFF000, 0, 0, 2, 8'h90, 1};
      vecs[6]  = '{1, 32'h008000EF, 0, 0, 0, 0, 0, 1, 32'h8, 0, 0, 1, 8'h12, 0};
      vecs[7]  = '{1, 32'h00008067, 32'h200, 0, 0, 0, 0, 1, 32'h0, 32'h200, 0, 0, 8'h82, 0};
      vecs[8]  = '{1, 32'h00000013, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0, 8'h80, 0};
      vecs[9]  = '{1, 32'h0000007F, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0, 8'h01, 0};
      vecs[10] = '{1, 32'h0000A303, 32'h300, 0, 0, 0, 0, 1, 32'h0, 32'h300, 0, 6, 8'hD8, 0};
      vecs[11] = '{1, 32'h00030337, 0, 0, 0, 0, 0, 1, 32'h00030000, 0, 0, 6, 8'h90, 0};
      vecs[12] = '{1, 32'h0000A003, 32'h400, 0, 0, 0, 0, 1, 32'h0, 32'h400, 0, 0, 8'hC8, 0};
      vecs[13] = '{1, 32'h002003B3, 0, 9, 0, 0, 0, 1, 32'h0, 0, 9, 7, 8'h10, 0};
      vecs[14] = '{1, 32'h002081B3, 1, 2, 1, 1, 32'hDEADBEEF, 1, 32'h0, 32'hDEADBEEF, 2, 3, 8'h10, 0};
      vecs[15] = '{1, 32'h002081B3, 1, 2, 1, 0, 32'hDEADBEEF, 1, 32'h0, 1, 2, 3, 8'h10, 0};
      vecs[16] = '{1, 32'h002081B3, 1, 2, 1, 2, 32'hCAFE0000, 1, 32'h0, 1, 32'hCAFE0000, 3, 8'h10, 0};
      vecs[17] = '{1, 32'h002081B3, 1, 2, 0, 1, 32'hDEADBEEF, 1, 32'h0, 1, 2, 3, 8'h10, 0};
      vecs[18] = '{0, 32'h002081B3, 1, 2, 0, 0, 0, 0, 32'h0, 0, 0, 0, 8'h00, 0};
      vecs[19] = '{1, 32'h402081B3, 5, 3, 0, 0, 0, 1, 32'h0, 5, 3, 3, 8'h10, 1};

      rst_n = 1'b0; ex_flush = 1'b0; ex_hold = 1'b0;
      wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0; id_pc = 32'h40;
      drive(1, 32'h0000A303, 32'h77, 32'h88);
      tick();
      tick();
      chk("reset_ex_valid", {31'b0, ex_valid}, 32'h0);
      chk("reset_ctrl", {24'b0, ctrl_now()}, 32'h0);
      chk("reset_imm_pc", ex_imm | ex_pc | ex_rs1_val, 32'h0);
      chk("reset_stall", {31'b0, stall}, 32'h0);

      // Reset released, then add x3,x1,x2
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 32'h002081B3, 1, 2);
      tick();
      chk("add_valid", {31'b0, ex_valid}, 32'h1);
      chk("add_rd", {27'b0, ex_rd}, 32'd3);
      chk("add_regwrite", {31'b0, ex_regwrite}, 32'h1);
      chk("add_rs_vals", {ex_rs1_val[15:0], ex_rs2_val[15:0]}, 32'h0001_0002);
      chk("add_stall", {31'b0, stall}, 32'h0);

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         drive(vecs[i].vin, vecs[i].instr, vecs[i].rf1, vecs[i].rf2);
         wb_regwrite = vecs[i].wbr; wb_rd = vecs[i].wbrd; wb_data = vecs[i].wbd;
         id_pc = 32'h100 + 32'(i * 4);
         #1;
         chk($sformatf("v%0d_stall", i), {31'b0, stall}, 32'h0);
         tick();
         chk($sformatf("v%0d_valid", i), {31'b0, ex_valid}, {31'b0, vecs[i].ev});
         chk($sformatf("v%0d_pc", i), ex_pc, vecs[i].ev ? 32'h100 + 32'(i * 4) : 32'h0);
         chk($sformatf("v%0d_imm", i), ex_imm, vecs[i].eimm);
         chk($sformatf("v%0d_rs1_val", i), ex_rs1_val, vecs[i].ev1);
         chk($sformatf("v%0d_rs2_val", i), ex_rs2_val, vecs[i].ev2);
         chk($sformatf("v%0d_rd", i), {27'b0, ex_rd}, {27'b0, vecs[i].erd});
         chk($sformatf("v%0d_ctrl", i), {24'b0, ctrl_now()}, {24'b0, vecs[i].ectrl});
         chk($sformatf("v%0d_f7b5", i), {31'b0, ex_funct7b5}, {31'b0, vecs[i].ef7});
      end
      wb_regwrite = 1'b0;

      // Load-use: lw x6 then add x7,x6,x2 -> one stall, bubble, then capture
      @(negedge clk);
      drive(1, 32'h0000A303, 32'h10, 0);
      tick();
      @(negedge clk);
      drive(1, 32'h002303B3, 32'h11, 32'h22);
      #1;
      chk("lu_stall_first", {31'b0, stall}, 32'h1);
      tick();
      chk("lu_bubble_valid", {31'b0, ex_valid}, 32'h0);
      chk("lu_bubble_ctrl", {24'b0, ctrl_now()}, 32'h0);
      chk("lu_stall_cleared", {31'b0, stall}, 32'h0);
      tick();
      chk("lu_add_valid", {31'b0, ex_valid}, 32'h1);
      chk("lu_add_rd_rs1", {22'b0, ex_rd, ex_rs1}, {22'b0, 5'd7, 5'd6});
      chk("lu_add_funct3", {29'b0, ex_funct3}, 32'h0);

      // Flush coinciding with load-use: flush wins, no stall
      @(negedge clk);
      drive(1, 32'h0000A303, 0, 0);
      tick();
      @(negedge clk);
      drive(1, 32'h002303B3, 0, 0);
      ex_flush = 1'b1;
      #1;
      chk("flush_stall", {31'b0, stall}, 32'h0);
      tick();
      chk("flush_valid", {31'b0, ex_valid}, 32'h0);
      chk("flush_fields", ex_imm | ex_rs1_val | ex_pc | {27'b0, ex_rd}, 32'h0);
      @(negedge clk);
      ex_flush = 1'b0;
      tick();
      chk("post_flush_capture", {26'b0, ex_valid, ex_rd}, {26'b0, 1'b1, 5'd7});

      // Hold for three cycles keeps the register frozen
      @(negedge clk);
      drive(1, 32'h123450B7, 0, 0);
      tick();
      @(negedge clk);
      drive(1, 32'hFFF00293, 32'h5, 32'h6);
      ex_hold = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("hold%0d_imm", c), ex_imm, 32'h12345000);
         chk($sformatf("hold%0d_rd", c), {27'b0, ex_rd}, 32'd1);
         chk($sformatf("hold%0d_ctrl", c), {24'b0, ctrl_now()}, 32'h90);
      end
      @(negedge clk);
      ex_hold = 1'b0;
      tick();
      chk("post_hold_capture", ex_imm, 32'hFFFFFFFF);

      // Hold masks the stall of a pending load-use
      @(negedge clk);
      drive(1, 32'h0000A303, 0, 0);
      tick();
      @(negedge clk);
      drive(1, 32'h002303B3, 0, 0);
      ex_hold = 1'b1;
      #1;
      chk("hold_lu_stall", {31'b0, stall}, 32'h0);
      tick();
      chk("hold_lu_frozen", {26'b0, ex_memread, ex_rd}, {26'b0, 1'b1, 5'd6});
      @(negedge clk);
      ex_hold = 1'b0;
      #1;
      chk("unhold_lu_stall", {31'b0, stall}, 32'h1);

      // Reset mid-stall clears everything at that edge
      rst_n = 1'b0;
      tick();
      chk("rst_mid_valid", {31'b0, ex_valid}, 32'h0);
      chk("rst_mid_fields", {24'b0, ctrl_now()} | {27'b0, ex_rd}, 32'h0);
      chk("rst_mid_stall", {31'b0, stall}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
